hash_seq_ctrl: RTL

Parametrised sequencer that drives one hash job through the external hash stub: it opens an input-RAM load window, streams a programmable number of bytes from RAM A to the stub, holds the stub request until the stub finishes, then streams the digest into RAM B. It supports four hash modes and variable input and output lengths, and has an optional watchdog. It sits between the top-level job interface and the SHAKE/SHA3 stub, and keeps its own byte counter.

---
 rtl/hash_seq_ctrl_if.sv | 40 ++++
 rtl/hash_seq_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/hash_seq_ctrl_if.sv
// Job / stub / RAM signal bundle for hash_seq_ctrl.
// The master modport is the sequencer side and the slave modport is the environment side.
interface hash_seq_ctrl_if #(
    parameter int IN_MAX  = 32,
    parameter int OUT_MAX = 168
);
    localparam int ACW = $clog2(IN_MAX + 1);
    localparam int OCW = $clog2(OUT_MAX + 1);

    logic           en;
    logic           full_in;
    logic [1:0]     mode;
    logic [ACW-1:0] in_len;
    logic [OCW-1:0] out_len;
    logic           hash_done;

    logic           ram_a_we_ok;
    logic           readin_ok;
    logic           rd_en;
    logic [ACW-1:0] rd_addr;
    logic           hash_req;
    logic [1:0]     hash_mode;
    logic           wr_en;
    logic [OCW-1:0] wr_addr;
    logic           busy;
    logic           done;
    logic           err;

    modport master (
        input  en, full_in, mode, in_len, out_len, hash_done,
        output ram_a_we_ok, readin_ok, rd_en, rd_addr, hash_req, hash_mode,
               wr_en, wr_addr, busy, done, err
    );

    modport slave (
        output en, full_in, mode, in_len, out_len, hash_done,
        input  ram_a_we_ok, readin_ok, rd_en, rd_addr, hash_req, hash_mode,
               wr_en, wr_addr, busy, done, err
    );
endinterface

// File: rtl/hash_seq_ctrl.sv
// Sequencer for one hash job: load window, absorb from RAM A, stub handshake, squeeze to RAM B.
// Optional WAIT watchdog is enabled by defining HASH_SEQ_TIMEOUT_EN.
module hash_seq_ctrl #(
    parameter int IN_MAX  = 32,
    parameter int OUT_MAX = 168,
    parameter int TIMEOUT = 1024
) (
    input  logic            clk,
    input  logic            reset,
    hash_seq_ctrl_if.master bus
);
    localparam int ACW = $clog2(IN_MAX + 1);
    localparam int OCW = $clog2(OUT_MAX + 1);
`ifdef HASH_SEQ_TIMEOUT_EN
    localparam int TW  = $clog2(TIMEOUT);
`else
    localparam int TW  = 1;
`endif
    localparam int CW0 = (ACW > OCW) ? ACW : OCW;
    localparam int CW  = (CW0 > TW) ? CW0 : TW;

    typedef enum logic [2:0] {
        S_IDLE, S_ABSORB, S_KICK, S_WAIT, S_SQUEEZE, S_DONE, S_ERR
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [ACW-1:0] lin_q, lin_d, lin_new;
    logic [OCW-1:0] lout_q, lout_d, lout_new;
    logic [1:0]     mode_q, mode_d;

    logic           ram_a_we_ok_q, ram_a_we_ok_d;
    logic           readin_ok_q, readin_ok_d;
    logic           rd_en_q, rd_en_d;
    logic [ACW-1:0] rd_addr_q, rd_addr_d;
    logic           hash_req_q, hash_req_d;
    logic           wr_en_q, wr_en_d;
    logic [OCW-1:0] wr_addr_q, wr_addr_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
`ifdef HASH_SEQ_TIMEOUT_EN
    logic           err_q, err_d;
`endif

    // Job latch values: SHA3 modes have a fixed digest length, SHAKE squeezes a clamped out_len.
    always_comb begin
        lin_new = (bus.in_len > ACW'(IN_MAX)) ? ACW'(IN_MAX) : bus.in_len;
        case (bus.mode)
            2'd2:    lout_new = OCW'(32);
            2'd3:    lout_new = OCW'(64);
            default: lout_new = (bus.out_len > OCW'(OUT_MAX)) ? OCW'(OUT_MAX) : bus.out_len;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lin_d   = lin_q;
        lout_d  = lout_q;
        mode_d  = mode_q;
`ifdef HASH_SEQ_TIMEOUT_EN
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.full_in) begin
                    lin_d   = lin_new;
                    lout_d  = lout_new;
                    mode_d  = bus.mode;
                    cnt_d   = '0;
`ifdef HASH_SEQ_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = (lin_new != '0) ? S_ABSORB : S_KICK;
                end
            end
            S_ABSORB: begin
                if (cnt_q == CW'(lin_q) - CW'(1)) state_d = S_KICK;
                else                              cnt_d   = cnt_q + CW'(1);
            end
            S_KICK: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.hash_done) begin
                    cnt_d   = '0;
                    state_d = (lout_q != '0) ? S_SQUEEZE : S_DONE;
                end
`ifdef HASH_SEQ_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
`endif
            end
            S_SQUEEZE: begin
                if (cnt_q == CW'(lout_q) - CW'(1)) state_d = S_DONE;
                else                               cnt_d   = cnt_q + CW'(1);
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state occupancy.
    always_comb begin
        ram_a_we_ok_d = (state_d == S_IDLE);
        readin_ok_d   = (state_d == S_IDLE) && !ram_a_we_ok_q;
        rd_en_d       = (state_d == S_ABSORB);
        rd_addr_d     = rd_en_d ? ACW'(cnt_d) : '0;
        hash_req_d    = (state_d == S_KICK) || (state_d == S_WAIT);
        wr_en_d       = (state_d == S_SQUEEZE);
        wr_addr_d     = wr_en_d ? OCW'(cnt_d) : '0;
        busy_d        = (state_d != S_IDLE);
        done_d        = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            lin_q         <= '0;
            lout_q        <= '0;
            mode_q        <= '0;
            ram_a_we_ok_q <= 1'b0;
            readin_ok_q   <= 1'b0;
            rd_en_q       <= 1'b0;
            rd_addr_q     <= '0;
            hash_req_q    <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
`ifdef HASH_SEQ_TIMEOUT_EN
            err_q         <= 1'b0;
`endif
        end else if (bus.en) begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            lin_q         <= lin_d;
            lout_q        <= lout_d;
            mode_q        <= mode_d;
            ram_a_we_ok_q <= ram_a_we_ok_d;
            readin_ok_q   <= readin_ok_d;
            rd_en_q       <= rd_en_d;
            rd_addr_q     <= rd_addr_d;
            hash_req_q    <= hash_req_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
`ifdef HASH_SEQ_TIMEOUT_EN
            err_q         <= err_d;
`endif
        end
    end

    assign bus.ram_a_we_ok = ram_a_we_ok_q;
    assign bus.readin_ok   = readin_ok_q;
    assign bus.rd_en       = rd_en_q;
    assign bus.rd_addr     = rd_addr_q;
    assign bus.hash_req    = hash_req_q;
    assign bus.hash_mode   = mode_q;
    assign bus.wr_en       = wr_en_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
`ifdef HASH_SEQ_TIMEOUT_EN
    assign bus.err         = err_q;
`else
    assign bus.err         = 1'b0;
`endif
endmodule
